// File: rtl/multicycle_control_pkg.sv
// Shared MIPS definitions: opcodes, ALU operation codes, mux selects,
// controller state encodings and the packed control word.
package multicycle_control_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALUOP_RTYPE = 3'b111;
   localparam logic [2:0] ALUOP_ADD   = 3'b110;
   localparam logic [2:0] ALUOP_OR    = 3'b101;
   localparam logic [2:0] ALUOP_SUB   = 3'b100;
   localparam logic [2:0] ALUOP_IDLE  = 3'b000;

   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // The branch state is split by flavour so that the condition enable is
   // a pure function of state rather than of the opcode held in IR.
   // Encodings 14 and 15 are unused and recover to FETCH.
   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_ADDI_EXEC = 4'd8,
      S_ORI_EXEC  = 4'd9,
      S_I_WB      = 4'd10,
      S_BRANCH_EQ = 4'd11,
      S_BRANCH_NE = 4'd12,
      S_JUMP      = 4'd13
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond_eq;
      logic       pc_write_cond_ne;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_op;
      logic       retire;
      logic       illegal;
   } ctrl_t;

   // True for every opcode this controller knows how to sequence.
   function automatic logic opcode_legal(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_ADDI, OP_ORI, OP_LW, OP_SW,
         OP_BEQ, OP_BNE, OP_J: opcode_legal = 1'b1;
         default:              opcode_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle controller and the MIPS datapath.
interface multicycle_control_if;
   import multicycle_control_pkg::*;

   logic [5:0] Opcode;
   logic       MemReady;
   logic       PCWrite;
   logic       PCWriteCondEQ;
   logic       PCWriteCondNE;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       MemtoReg;
   logic       RegDst;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] PCSource;
   logic [2:0] ALUOp;
   logic       Retire;
   logic       Illegal;

   modport master (
      input  Opcode, MemReady,
      output PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite,
             IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
             ALUOp, Retire, Illegal
   );

   modport slave (
      output Opcode, MemReady,
      input  PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite,
             IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
             ALUOp, Retire, Illegal
   );
endinterface

// File: rtl/multicycle_control_output_decoder.sv
// Pure combinational map from controller state to the datapath control word.
// MemReady only gates the enables that complete a memory access.
module control_output_decoder
   import multicycle_control_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   input  logic   legal,
   output ctrl_t  ctrl
);

   // Everything defaults to idle; each state raises only what it needs, and
   // unused encodings fall through with every enable low.
   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_source = PCSRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH2;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.illegal   = ~legal;
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_READ: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.retire     = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
            ctrl.retire    = mem_ready;
         end
         S_R_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RT;
            ctrl.alu_op    = ALUOP_RTYPE;
         end
         S_R_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
            ctrl.retire    = 1'b1;
         end
         S_ADDI_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_ORI_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_OR;
         end
         S_I_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.retire    = 1'b1;
         end
         S_BRANCH_EQ: begin
            ctrl.alu_src_a        = 1'b1;
            ctrl.alu_src_b        = SRCB_RT;
            ctrl.alu_op           = ALUOP_SUB;
            ctrl.pc_source        = PCSRC_ALUOUT;
            ctrl.pc_write_cond_eq = 1'b1;
            ctrl.retire           = 1'b1;
         end
         S_BRANCH_NE: begin
            ctrl.alu_src_a        = 1'b1;
            ctrl.alu_src_b        = SRCB_RT;
            ctrl.alu_op           = ALUOP_SUB;
            ctrl.pc_source        = PCSRC_ALUOUT;
            ctrl.pc_write_cond_ne = 1'b1;
            ctrl.retire           = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
            ctrl.retire    = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: Moore FSM sequencing fetch, decode, execute,
// memory and writeback, with a memory handshake that stretches accesses.
module multicycle_control
   import multicycle_control_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   multicycle_control_if.master   bus
);

   state_t state;
   state_t next_state;
   ctrl_t  ctrl;

   control_output_decoder u_decoder (
      .state     (state),
      .mem_ready (bus.MemReady),
      .legal     (opcode_legal(bus.Opcode)),
      .ctrl      (ctrl)
   );

   // State register; reset drops any in-flight instruction back to FETCH.
   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= next_state;
   end

   // Next-state selection; opcode is consulted only once IR holds it.
   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_FETCH:     next_state = bus.MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.Opcode)
               OP_RTYPE:     next_state = S_R_EXEC;
               OP_ADDI:      next_state = S_ADDI_EXEC;
               OP_ORI:       next_state = S_ORI_EXEC;
               OP_LW, OP_SW: next_state = S_MEM_ADDR;
               OP_BEQ:       next_state = S_BRANCH_EQ;
               OP_BNE:       next_state = S_BRANCH_NE;
               OP_J:         next_state = S_JUMP;
               default:      next_state = S_FETCH;
            endcase
         end
         S_MEM_ADDR:  next_state = (bus.Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  next_state = bus.MemReady ? S_MEM_WB : S_MEM_READ;
         S_MEM_WRITE: next_state = bus.MemReady ? S_FETCH : S_MEM_WRITE;
         S_R_EXEC:    next_state = S_R_WB;
         S_ADDI_EXEC: next_state = S_I_WB;
         S_ORI_EXEC:  next_state = S_I_WB;
         default:     next_state = S_FETCH;
      endcase
   end

   // Drive the datapath; while reset is high every control is forced idle
   // so an abandoned access or write never leaks out.
   always_comb begin
      bus.PCWrite       = ~reset & ctrl.pc_write;
      bus.PCWriteCondEQ = ~reset & ctrl.pc_write_cond_eq;
      bus.PCWriteCondNE = ~reset & ctrl.pc_write_cond_ne;
      bus.IorD          = ~reset & ctrl.i_or_d;
      bus.MemRead       = ~reset & ctrl.mem_read;
      bus.MemWrite      = ~reset & ctrl.mem_write;
      bus.IRWrite       = ~reset & ctrl.ir_write;
      bus.MemtoReg      = ~reset & ctrl.mem_to_reg;
      bus.RegDst        = ~reset & ctrl.reg_dst;
      bus.RegWrite      = ~reset & ctrl.reg_write;
      bus.ALUSrcA       = ~reset & ctrl.alu_src_a;
      bus.ALUSrcB       = reset ? SRCB_RT    : ctrl.alu_src_b;
      bus.PCSource      = reset ? PCSRC_ALU  : ctrl.pc_source;
      bus.ALUOp         = reset ? ALUOP_IDLE : ctrl.alu_op;
      bus.Retire        = ~reset & ctrl.retire;
      bus.Illegal       = ~reset & ctrl.illegal;
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed checks of the multicycle controller's per-cycle control word,
// followed by a random opcode/handshake stream with invariant checks.
module tb_multicycle_control;

   logic clk;
   logic reset;
   int   check_count = 0;
   int   error_count = 0;

   multicycle_control_if bus ();

   multicycle_control dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Builds a 20-bit expected word in the bench's own field order.
   function automatic logic [19:0] cw(input logic pcw, eq, ne, iord, mr, mw, irw, m2r, rd, rw, asa,
                                      input logic [1:0] asb, pcs, input logic [2:0] aop,
                                      input logic ret, ill);
      return {pcw, eq, ne, iord, mr, mw, irw, m2r, rd, rw, asa, asb, pcs, aop, ret, ill};
   endfunction

   function automatic logic [19:0] observed_word();
      return {bus.PCWrite, bus.PCWriteCondEQ, bus.PCWriteCondNE, bus.IorD, bus.MemRead,
              bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
              bus.ALUSrcB, bus.PCSource, bus.ALUOp, bus.Retire, bus.Illegal};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One clock cycle: drive inputs on the falling edge, then check the word.
   task automatic applyStimulus(input logic [5:0] op, input logic rdy, input logic rst,
                                input string tag, input logic [19:0] expected);
      @(negedge clk);
      bus.Opcode   = op;
      bus.MemReady = rdy;
      reset        = rst;
      #1;
      checkOutput(tag, {12'b0, observed_word()}, {12'b0, expected});
   endtask

   logic [19:0] e_zero, e_fetch, e_fetch_stall, e_decode, e_decode_ill, e_r_exec, e_r_wb;
   logic [19:0] e_mem_addr, e_mem_read, e_mem_wb, e_mem_write, e_mem_write_stall;
   logic [19:0] e_addi_exec, e_ori_exec, e_i_wb, e_beq, e_bne, e_jump;

   logic [5:0] ops [10] = '{6'b000000, 6'b001000, 6'b001101, 6'b100011, 6'b101011,
                            6'b000100, 6'b000101, 6'b000010, 6'b111111, 6'b010000};

   initial begin
      int   legal_count;
      int   retire_count;
      int   pick;
      logic pending;
      logic done;

      e_zero            = '0;
      e_fetch           = cw(1,0,0,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 3'b110, 0,0);
      e_fetch_stall     = cw(0,0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 3'b110, 0,0);
      e_decode          = cw(0,0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b110, 0,0);
      e_decode_ill      = cw(0,0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b110, 0,1);
      e_r_exec          = cw(0,0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b111, 0,0);
      e_r_wb            = cw(0,0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 3'b000, 1,0);
      e_mem_addr        = cw(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b110, 0,0);
      e_mem_read        = cw(0,0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0,0);
      e_mem_wb          = cw(0,0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b000, 1,0);
      e_mem_write       = cw(0,0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 1,0);
      e_mem_write_stall = cw(0,0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0,0);
      e_addi_exec       = cw(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b110, 0,0);
      e_ori_exec        = cw(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b101, 0,0);
      e_i_wb            = cw(0,0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 3'b000, 1,0);
      e_beq             = cw(0,1,0,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b100, 1,0);
      e_bne             = cw(0,0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b100, 1,0);
      e_jump            = cw(1,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b000, 1,0);

      reset        = 1'b1;
      bus.Opcode   = 6'b000000;
      bus.MemReady = 1'b1;

      // Reset for two cycles, then an R-type instruction.
      applyStimulus(6'b000000, 1, 1, "reset_c1", e_zero);
      applyStimulus(6'b000000, 1, 1, "reset_c2", e_zero);
      applyStimulus(6'b000000, 1, 0, "r_fetch",  e_fetch);
      applyStimulus(6'b000000, 1, 0, "r_decode", e_decode);
      applyStimulus(6'b000000, 1, 0, "r_exec",   e_r_exec);
      applyStimulus(6'b000000, 1, 0, "r_wb",     e_r_wb);

      // LW with a fetch stall and three MEM_READ stall cycles.
      applyStimulus(6'b100011, 0, 0, "lw_fetch_stall", e_fetch_stall);
      applyStimulus(6'b100011, 1, 0, "lw_fetch",       e_fetch);
      applyStimulus(6'b100011, 1, 0, "lw_decode",      e_decode);
      applyStimulus(6'b100011, 1, 0, "lw_addr",        e_mem_addr);
      applyStimulus(6'b100011, 0, 0, "lw_read_st1",    e_mem_read);
      applyStimulus(6'b100011, 0, 0, "lw_read_st2",    e_mem_read);
      applyStimulus(6'b100011, 0, 0, "lw_read_st3",    e_mem_read);
      applyStimulus(6'b100011, 1, 0, "lw_read_done",   e_mem_read);
      applyStimulus(6'b100011, 1, 0, "lw_wb",          e_mem_wb);

      // BNE and BEQ, three cycles each.
      applyStimulus(6'b000101, 1, 0, "bne_fetch",  e_fetch);
      applyStimulus(6'b000101, 1, 0, "bne_decode", e_decode);
      applyStimulus(6'b000101, 1, 0, "bne_branch", e_bne);
      applyStimulus(6'b000100, 1, 0, "beq_fetch",  e_fetch);
      applyStimulus(6'b000100, 1, 0, "beq_decode", e_decode);
      applyStimulus(6'b000100, 1, 0, "beq_branch", e_beq);

      // Unsupported opcode, then back to FETCH for a jump.
      applyStimulus(6'b111111, 1, 0, "ill_fetch",  e_fetch);
      applyStimulus(6'b111111, 1, 0, "ill_decode", e_decode_ill);
      applyStimulus(6'b000010, 1, 0, "j_fetch",    e_fetch);
      applyStimulus(6'b000010, 1, 0, "j_decode",   e_decode);
      applyStimulus(6'b000010, 1, 0, "j_jump",     e_jump);

      // ADDI and ORI.
      applyStimulus(6'b001000, 1, 0, "addi_fetch",  e_fetch);
      applyStimulus(6'b001000, 1, 0, "addi_decode", e_decode);
      applyStimulus(6'b001000, 1, 0, "addi_exec",   e_addi_exec);
      applyStimulus(6'b001000, 1, 0, "addi_wb",     e_i_wb);
      applyStimulus(6'b001101, 1, 0, "ori_fetch",   e_fetch);
      applyStimulus(6'b001101, 1, 0, "ori_decode",  e_decode);
      applyStimulus(6'b001101, 1, 0, "ori_exec",    e_ori_exec);
      applyStimulus(6'b001101, 1, 0, "ori_wb",      e_i_wb);

      // SW stalled in MEM_WRITE, then reset while still stalled.
      applyStimulus(6'b101011, 1, 0, "sw_fetch",       e_fetch);
      applyStimulus(6'b101011, 1, 0, "sw_decode",      e_decode);
      applyStimulus(6'b101011, 1, 0, "sw_addr",        e_mem_addr);
      applyStimulus(6'b101011, 0, 0, "sw_write_stall", e_mem_write_stall);
      applyStimulus(6'b101011, 0, 1, "sw_reset_stall", e_zero);
      applyStimulus(6'b101011, 1, 0, "post_rst_fetch", e_fetch);

      // A complete SW with no stall, ending on its retiring write.
      applyStimulus(6'b101011, 1, 0, "sw2_decode", e_decode);
      applyStimulus(6'b101011, 1, 0, "sw2_addr",   e_mem_addr);
      applyStimulus(6'b101011, 1, 0, "sw2_write",  e_mem_write);

      // Random opcode stream; a new opcode is chosen only after IR loads.
      legal_count  = 0;
      retire_count = 0;
      pending      = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (pending) begin
            pick       = $urandom_range(0, 9);
            bus.Opcode = ops[pick];
            if (pick < 8) legal_count++;
         end
         bus.MemReady = ($urandom_range(0, 3) != 0);
         #1;
         checkOutput("excl_mw_pw_rw", {31'b0, bus.MemWrite & (bus.PCWrite | bus.RegWrite)}, 32'd0);
         checkOutput("excl_mr_mw",    {31'b0, bus.MemRead & bus.MemWrite}, 32'd0);
         if (bus.Retire) retire_count++;
         pending = bus.IRWrite;
      end

      // Drain the in-flight instruction until the next fetch completes.
      done = pending;
      for (int i = 0; i < 12 && !done; i++) begin
         @(negedge clk);
         bus.MemReady = 1'b1;
         #1;
         checkOutput("drain_excl", {31'b0, bus.MemRead & bus.MemWrite}, 32'd0);
         if (bus.Retire) retire_count++;
         done = bus.IRWrite;
      end
      checkOutput("drain_done",   {31'b0, done}, 32'd1);
      checkOutput("retire_count", retire_count, legal_count);

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL: clk  input  1  single rising-edge clock.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: Opcode  input  6  instruction[31:26] from IR; valid from DECODE onward.
REQ-004 SHALL: MemReady  input  1  memory handshake; access completes in the cycle it is sampled high.
REQ-005 SHALL: PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  datapath controls.
REQ-006 SHALL: ALUSrcB  output  2  00 rt, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-007 SHALL: PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-008 SHALL: ALUOp  output  3  feeds ALU control: 111 R-type(funct), 110 add, 101 or, 100 subtract, 000 idle.
REQ-009 SHALL: Retire  output  1  one-cycle pulse on the last cycle of each instruction.
REQ-010 SHALL: Illegal  output  1  one-cycle pulse in DECODE for an unsupported opcode.

Function
REQ-011 SHALL: Moore FSM; all outputs decoded from current state (and MemReady only for enables gated by it); no output depends on Opcode outside DECODE.
REQ-012 SHALL: supported opcodes: R 000000, ADDI 001000, ORI 001101, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010.
REQ-013 SHALL: FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=110, PCSource=00; IRWrite and PCWrite asserted only when MemReady=1; stay in FETCH while MemReady=0, else go to DECODE.
REQ-014 SHALL: DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=110 (branch target into ALUOut); next: R->R_EXEC, ADDI->ADDI_EXEC, ORI->ORI_EXEC, LW/SW->MEM_ADDR, BEQ/BNE->BRANCH, J->JUMP, other->FETCH with Illegal=1.
REQ-015 SHALL: MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=110; next MEM_READ (LW) or MEM_WRITE (SW).
REQ-016 SHALL: MEM_READ: MemRead=1, IorD=1; hold until MemReady=1, then MEM_WB. MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, Retire=1; next FETCH.
REQ-017 SHALL: MEM_WRITE: MemWrite=1, IorD=1; hold until MemReady=1; Retire=1 in completing cycle; next FETCH.
REQ-018 SHALL: R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=111; next R_WB: RegWrite=1, RegDst=1, MemtoReg=0, Retire=1; next FETCH.
REQ-019 SHALL: ADDI_EXEC/ORI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=110/101; next I_WB: RegWrite=1, RegDst=0, MemtoReg=0, Retire=1; next FETCH.
REQ-020 SHALL: BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=100, PCSource=01, PCWriteCondEQ=1 (BEQ) or PCWriteCondNE=1 (BNE), Retire=1; next FETCH.
REQ-021 SHALL: JUMP: PCWrite=1, PCSource=10, Retire=1; next FETCH.
REQ-022 SHALL: latency (MemReady always 1): R/ADDI/ORI 4, LW 5, SW 4, BEQ/BNE 3, J 3 cycles; each MemReady=0 cycle adds exactly one.
REQ-023 SHALL: PCWrite and RegWrite never both asserted with MemWrite; MemRead and MemWrite never simultaneously 1.
REQ-024 SHALL: unreachable state encodings transition to FETCH with all enables 0.

Reset
REQ-025 SHALL: while reset=1, all 1-bit outputs 0, ALUSrcB=00, PCSource=00, ALUOp=000, regardless of state.
REQ-026 SHALL: state register loads FETCH on the clock edge where reset=1; reset mid-instruction (including during a MemReady stall) abandons it with no write enable asserted.
REQ-027 SHALL: first cycle after reset deasserts is FETCH.

Structure
REQ-028 SHALL: opcode constants, ALUOp encodings, and state encodings live in the shared MIPS definitions include, also used by ALU control.
REQ-029 SHALL: one sub-module, control_output_decoder (state -> control word), combinational; next-state logic and state register stay in multicycle_control.

Verification
REQ-030 SHALL: reset high 2 cycles, release, Opcode=000000, MemReady=1 -> FETCH,DECODE,R_EXEC,R_WB; ALUOp 110,110,111,000; RegWrite=1 only in cycle 4; Retire in cycle 4.
REQ-031 SHALL: LW with MemReady low 3 cycles in MEM_READ -> 8 total cycles; MemRead/IorD held throughout; RegWrite=1 only in MEM_WB.
REQ-032 SHALL: BNE (000101) -> 3 cycles; BRANCH has ALUOp=100, PCWriteCondNE=1, PCWriteCondEQ=0, PCSource=01.
REQ-033 SHALL: Opcode=111111 -> Illegal pulses in DECODE, no write enable, returns to FETCH next cycle.
REQ-034 SHALL: reset asserted during MEM_WRITE stall -> MemWrite=0 that cycle; FETCH follows release.
REQ-035 SHALL: random opcode stream with random MemReady -> checker confirms REQ-023 every cycle and one Retire per legal instruction.
